// File: rtl/reg_write_deserializer_pkg.sv
// rtl/reg_write_deserializer_pkg.sv - shared types and constants for the register write deserializer
package reg_write_deserializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    D3,
    D2,
    D1,
    D0,
    COMMIT
  } state_e;

  localparam logic [7:0]  HDR_WR_DEFAULT  = 8'hA5;
  localparam int unsigned NREG_DEFAULT    = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  // Address map of the downstream control register bank
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h01;
  localparam logic [7:0] REG_IRQ_EN   = 8'h02;
  localparam logic [7:0] REG_IRQ_STAT = 8'h03;
  localparam logic [7:0] REG_LAST     = 8'h0F;

  // States in which a frame is open and the inter-byte timeout runs
  function automatic logic in_frame(input state_e s);
    return (s == ADDR) || (s == D3) || (s == D2) || (s == D1) || (s == D0);
  endfunction

endpackage

// File: rtl/reg_write_deserializer_if.sv
// rtl/reg_write_deserializer_if.sv - byte stream input and register write bus
interface reg_write_deserializer_if #(
  parameter int unsigned NREG = 16
);
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic [31:0]     wr_data;
  logic [7:0]      wr_addr;
  logic [NREG-1:0] wr_sel;
  logic            wr_strobe;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, wr_data, wr_addr, wr_sel, wr_strobe
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, wr_data, wr_addr, wr_sel, wr_strobe
  );
endinterface

// File: rtl/reg_write_deserializer_sat_counter8.sv
// rtl/reg_write_deserializer_sat_counter8.sv - 8-bit saturating event counter, async active-low clear
module sat_counter8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/reg_write_deserializer.sv
// rtl/reg_write_deserializer.sv - assembles header/address/4-byte write frames into register write pulses
module reg_write_deserializer
  import reg_write_deserializer_pkg::*;
#(
  parameter int unsigned NREG    = NREG_DEFAULT,
  parameter logic [7:0]  HDR_WR  = HDR_WR_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  reg_write_deserializer_if.slave         bus,
  output logic [7:0]                      err_count,
  output logic                            busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          state_q,   state_d;
  logic [7:0]      addr_q,    addr_d;
  logic [31:0]     shadow_q,  shadow_d;
  logic [TW-1:0]   tmo_q,     tmo_d;
  logic            ready_q,   ready_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [NREG-1:0] wr_sel_q,  wr_sel_d;
  logic            strobe_q,  strobe_d;
  logic            err_inc;
  logic            accept;

  assign accept = bus.byte_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    shadow_d  = shadow_q;
    tmo_d     = '0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_sel_d  = '0;
    strobe_d  = 1'b0;
    err_inc   = 1'b0;

    if (in_frame(state_q)) begin
      if (accept) begin
        // A header byte here is payload; only the timeout resynchronises a frame
        unique case (state_q)
          ADDR:    begin addr_d = bus.byte_in; state_d = D3; end
          D3:      state_d = D2;
          D2:      state_d = D1;
          D1:      state_d = D0;
          default: state_d = COMMIT;
        endcase
        if (state_q != ADDR) begin
          shadow_d = {shadow_q[23:0], bus.byte_in};
        end
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d  = IDLE;
        shadow_d = '0;
        err_inc  = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else if (state_q == COMMIT) begin
      wr_data_d = shadow_q;
      wr_addr_d = addr_q;
      if (32'(addr_q) < NREG) begin
        wr_sel_d = NREG'(1) << addr_q;
        strobe_d = 1'b1;
      end else begin
        err_inc = 1'b1;
      end
      state_d = IDLE;
    end else if (accept) begin
      if (bus.byte_in == HDR_WR) begin
        state_d = ADDR;
      end else begin
        err_inc = 1'b1;
      end
    end

    ready_d = (state_d != COMMIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      shadow_q  <= '0;
      tmo_q     <= '0;
      ready_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_sel_q  <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      shadow_q  <= shadow_d;
      tmo_q     <= tmo_d;
      ready_q   <= ready_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_sel_q  <= wr_sel_d;
      strobe_q  <= strobe_d;
    end
  end

  sat_counter8 u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (err_inc),
    .count   (err_count)
  );

  assign bus.byte_ready = ready_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_sel     = wr_sel_q;
  assign bus.wr_strobe  = strobe_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_reg_write_deserializer.sv
// tb/tb_reg_write_deserializer.sv - directed self-checking bench for reg_write_deserializer
module tb_reg_write_deserializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] err_count;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int rdy_low = 0;

  int          stb_cyc[$];
  logic [15:0] stb_sel[$];
  logic [31:0] stb_data[$];

  reg_write_deserializer_if #(.NREG(16)) bus ();

  reg_write_deserializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      stb_cyc.push_back(cyc);
      stb_sel.push_back(bus.wr_sel);
      stb_data.push_back(bus.wr_data);
    end
    if (reset_n && !bus.byte_ready) rdy_low <= rdy_low + 1;
  end

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.byte_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) expect_eq("send_accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.byte_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, "_wr_data"},   64'(bus.wr_data),   64'd0);
    expect_eq({tag, "_wr_addr"},   64'(bus.wr_addr),   64'd0);
    expect_eq({tag, "_wr_sel"},    64'(bus.wr_sel),    64'd0);
    expect_eq({tag, "_wr_strobe"}, 64'(bus.wr_strobe), 64'd0);
    expect_eq({tag, "_err_count"}, 64'(err_count),     64'd0);
    expect_eq({tag, "_busy"},      64'(busy),          64'd0);
  endtask

  initial begin
    int n0;
    int r0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_eq("rst_ready", 64'(bus.byte_ready), 64'd0);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    expect_eq("rst_ready_pre_edge", 64'(bus.byte_ready), 64'd0);
    @(negedge clk);
    expect_eq("rst_ready_after", 64'(bus.byte_ready), 64'd1);
    @(posedge clk);
    #1;

    // single frame and its two-edge commit latency
    n0 = stb_cyc.size();
    send_frame(8'h03, 32'hDEADBEEF);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    expect_eq("a_commit_strobe", 64'(bus.wr_strobe), 64'd0);
    expect_eq("a_commit_ready",  64'(bus.byte_ready), 64'd0);
    expect_eq("a_commit_busy",   64'(busy), 64'd1);
    @(negedge clk);
    expect_eq("a_strobe", 64'(bus.wr_strobe), 64'd1);
    expect_eq("a_sel",    64'(bus.wr_sel),    64'h0008);
    expect_eq("a_data",   64'(bus.wr_data),   64'hDEADBEEF);
    expect_eq("a_addr",   64'(bus.wr_addr),   64'h03);
    @(negedge clk);
    expect_eq("a_strobe_off", 64'(bus.wr_strobe), 64'd0);
    expect_eq("a_data_hold",  64'(bus.wr_data),   64'hDEADBEEF);
    expect_eq("a_err", 64'(err_count), 64'd0);
    expect_eq("a_nstb", 64'(stb_cyc.size() - n0), 64'd1);
    idle(2);

    // back-to-back frames
    n0 = stb_cyc.size();
    r0 = rdy_low;
    send_frame(8'h00, 32'h00000001);
    send_frame(8'h0F, 32'hFFFFFFFF);
    idle(5);
    expect_eq("b2b_nstb", 64'(stb_cyc.size() - n0), 64'd2);
    if (stb_cyc.size() - n0 == 2) begin
      expect_eq("b2b_gap",   64'(stb_cyc[n0+1] - stb_cyc[n0]), 64'd7);
      expect_eq("b2b_sel0",  64'(stb_sel[n0]),    64'h0001);
      expect_eq("b2b_data0", 64'(stb_data[n0]),   64'h00000001);
      expect_eq("b2b_sel1",  64'(stb_sel[n0+1]),  64'h8000);
      expect_eq("b2b_data1", 64'(stb_data[n0+1]), 64'hFFFFFFFF);
    end
    expect_eq("b2b_ready_low", 64'(rdy_low - r0), 64'd2);

    // junk bytes before a valid frame
    n0 = stb_cyc.size();
    send_byte(8'h00);
    send_byte(8'h11);
    send_frame(8'h02, 32'h12345678);
    idle(4);
    expect_eq("junk_err", 64'(err_count), 64'd2);
    expect_eq("junk_nstb", 64'(stb_cyc.size() - n0), 64'd1);
    if (stb_cyc.size() > n0) begin
      expect_eq("junk_sel",  64'(stb_sel[n0]),  64'h0004);
      expect_eq("junk_data", 64'(stb_data[n0]), 64'h12345678);
    end

    // inter-byte timeout
    do_reset();
    n0 = stb_cyc.size();
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h12);
    bus.byte_valid = 1'b0;
    repeat (1023) @(posedge clk);
    @(negedge clk);
    expect_eq("tmo_busy_1023", 64'(busy), 64'd1);
    expect_eq("tmo_err_1023", 64'(err_count), 64'd0);
    @(negedge clk);
    expect_eq("tmo_busy_1024", 64'(busy), 64'd0);
    expect_eq("tmo_err", 64'(err_count), 64'd1);
    expect_eq("tmo_nstb", 64'(stb_cyc.size() - n0), 64'd0);
    @(posedge clk);
    #1;
    send_frame(8'h07, 32'hCAFEF00D);
    idle(4);
    expect_eq("tmo_next_nstb", 64'(stb_cyc.size() - n0), 64'd1);
    if (stb_cyc.size() > n0) expect_eq("tmo_next_sel", 64'(stb_sel[n0]), 64'h0080);
    expect_eq("tmo_next_err", 64'(err_count), 64'd1);

    // out-of-range address
    n0 = stb_cyc.size();
    send_frame(8'h20, 32'h0BADF00D);
    idle(3);
    expect_eq("oor_nstb", 64'(stb_cyc.size() - n0), 64'd0);
    expect_eq("oor_sel",  64'(bus.wr_sel),  64'd0);
    expect_eq("oor_data", 64'(bus.wr_data), 64'h0BADF00D);
    expect_eq("oor_addr", 64'(bus.wr_addr), 64'h20);
    expect_eq("oor_err",  64'(err_count),   64'd2);

    // reset in the middle of a frame
    n0 = stb_cyc.size();
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.byte_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    expect_eq("mid_rst_ready", 64'(bus.byte_ready), 64'd0);
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(10);
    @(negedge clk);
    check_reset_outputs("post_rst");
    expect_eq("post_rst_ready", 64'(bus.byte_ready), 64'd1);
    expect_eq("post_rst_nstb", 64'(stb_cyc.size() - n0), 64'd0);
    @(posedge clk);
    #1;

    // error counter saturation
    for (int i = 0; i < 254; i++) send_byte(8'h00);
    idle(1);
    expect_eq("sat_err_254", 64'(err_count), 64'd254);
    for (int i = 0; i < 6; i++) send_byte(8'h00);
    idle(1);
    expect_eq("sat_err_260", 64'(err_count), 64'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
